tlb_line_cache: RTL and testbench

//  Translation cache that sits directly upstream of the va_to_pa page-table walker.
//  - Translates 64-bit virtual addresses (Sv48 layout) to physical addresses.
//  - On a miss, starts one walk and caches the whole 8-PTE leaf line the walker returns
//    (the 8 PTEs for 8 adjacent 4 KiB pages); later accesses in that 32 KiB region hit.

---
 rtl/tlb_line_cache.sv | 162 ++++++++++++++++
 tb/tb_tlb_line_cache.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_line_cache.sv
// Fully-associative translation cache holding whole 8-PTE leaf lines.
// Misses start a single walk; the returned line is cached for later hits.
module tlb_line_cache #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int ENTRIES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        req_valid,
  input  logic [BUS_DATA_WIDTH-1:0]   req_vaddr,
  output logic                        req_ready,
  output logic                        resp_valid,
  output logic [BUS_DATA_WIDTH-1:0]   resp_paddr,
  output logic                        resp_fault,
  output logic                        walk_enable,
  output logic [BUS_DATA_WIDTH-1:0]   walk_vaddr,
  input  logic                        walk_ready,
  input  logic [BUS_DATA_WIDTH*8-1:0] walk_pte_array
);

  localparam int IW = $clog2(ENTRIES);
  localparam int LW = BUS_DATA_WIDTH * 8;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WREQ, WDROP, WWAIT, FILL
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ENTRIES-1:0]        valid;
  logic [32:0]               tag [ENTRIES];
  logic [LW-1:0]             line [ENTRIES];
  logic [IW-1:0]             rr_ptr;
  logic [BUS_DATA_WIDTH-1:0] vaddr_q;
  logic                      drop_fill;
  logic [BUS_DATA_WIDTH-1:0] paddr_q;
  logic                      fault_q;

  logic                      hit;
  logic [IW-1:0]             hit_idx;
  logic                      has_free;
  logic [IW-1:0]             free_idx;
  logic [IW-1:0]             victim;
  logic [2:0]                pidx;
  logic [LW-1:0]             src_line;
  logic [BUS_DATA_WIDTH-1:0] pte;
  logic                      fault;
  logic [BUS_DATA_WIDTH-1:0] paddr;
  logic                      accept;
  logic                      fill_wr;
  logic                      unused_bits;

  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == vaddr_q[47:15]) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Descending scan leaves the lowest invalid index selected.
  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        has_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign victim = has_free ? free_idx : rr_ptr;

  assign pidx = vaddr_q[14:12];
  assign src_line = (state == FILL) ? walk_pte_array
                                    : line[hit_idx];
  assign pte = src_line[int'(pidx)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
  assign fault = !pte[0];
  assign paddr = fault ? '0
                       : {8'b0, pte[53:10], vaddr_q[11:0]};
  assign unused_bits = ^{pte[63:54], pte[9:1]};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (req_valid && !flush) state_nx = LOOKUP;
      LOOKUP: state_nx = (hit && !flush) ? IDLE : WREQ;
      WREQ:   state_nx = WDROP;
      WDROP:  if (!walk_ready) state_nx = WWAIT;
      WWAIT:  if (walk_ready) state_nx = FILL;
      FILL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    resp_valid = 1'b0;
    walk_enable = 1'b0;
    resp_paddr = '0;
    resp_fault = 1'b0;
    walk_vaddr = '0;
    if (!reset) begin
      req_ready = (state == IDLE) && !flush;
      resp_valid = (state == LOOKUP && hit && !flush)
                || (state == FILL);
      walk_enable = (state == WREQ);
      resp_paddr = resp_valid ? paddr : paddr_q;
      resp_fault = resp_valid ? fault : fault_q;
      walk_vaddr = vaddr_q;
    end
  end

  assign accept = req_ready && req_valid;
  assign fill_wr = (state == FILL) && !drop_fill && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      rr_ptr <= '0;
      vaddr_q <= '0;
      drop_fill <= 1'b0;
      paddr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        vaddr_q <= req_vaddr;
        drop_fill <= 1'b0;
      end
      if (resp_valid) begin
        paddr_q <= paddr;
        fault_q <= fault;
      end
      // A flush during an outstanding walk still answers but must not cache.
      if (flush) begin
        valid <= '0;
        rr_ptr <= '0;
        if (state inside {WREQ, WDROP, WWAIT, FILL})
          drop_fill <= 1'b1;
      end else if (fill_wr) begin
        valid[victim] <= 1'b1;
        if (!has_free) rr_ptr <= rr_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fill_wr) begin
      tag[victim] <= vaddr_q[47:15];
      line[victim] <= walk_pte_array;
    end
  end

endmodule

// File: tb/tb_tlb_line_cache.sv
// Bench for tlb_line_cache: walker model plus response scoreboard.
// Expected translations come from the walker's line generator.
module tb_tlb_line_cache;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         flush_tb;
  logic         flush_w;
  logic         req_valid;
  logic [63:0]  req_vaddr;
  logic         req_ready;
  logic         resp_valid;
  logic [63:0]  resp_paddr;
  logic         resp_fault;
  logic         walk_enable;
  logic [63:0]  walk_vaddr;
  logic         walk_ready;
  logic [511:0] walk_pte_array;

  assign flush = flush_tb | flush_w;

  tlb_line_cache #(.BUS_DATA_WIDTH(64), .ENTRIES(4)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .req_valid(req_valid),
    .req_vaddr(req_vaddr),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_paddr(resp_paddr),
    .resp_fault(resp_fault),
    .walk_enable(walk_enable),
    .walk_vaddr(walk_vaddr),
    .walk_ready(walk_ready),
    .walk_pte_array(walk_pte_array)
  );

  localparam logic [63:0] T1 = 64'h0000_0040_1234_5678;

  typedef struct {
    logic [63:0] va;
    logic [63:0] pa;
    logic        f;
    bit          walk;
    int          c0;
    int          e0;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    en_cnt = 0;
  int    walk_lat = 4;
  int    drop_delay = 0;
  bit    flush_on_walk = 0;
  bit    walker_done = 1;
  bit    hold_pend = 0;
  logic [63:0] last_pa;
  logic        last_f;
  string cur = "init";

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] gen_pte(input logic [63:0] va,
                                          input int i);
    logic [32:0] t;
    logic [32:0] t1t;
    logic [43:0] ppn;
    t = va[47:15];
    t1t = T1[47:15];
    if (t == t1t && i == 5) return 64'h0000_0000_2000_0401;
    if (t == t1t && i == 0) return 64'h0;
    ppn = {11'b0, t} + 44'(i * 3 + 1);
    return {10'b0, ppn, 9'b0, (i != 6)};
  endfunction

  function automatic logic [511:0] build_line(input logic [63:0] va);
    logic [511:0] l;
    for (int i = 0; i < 8; i++) l[i*64 +: 64] = gen_pte(va, i);
    return l;
  endfunction

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Walker: drops ready after an optional delay, then returns the line.
  initial begin
    logic [63:0] wv;
    walk_ready = 0;
    walk_pte_array = '0;
    flush_w = 0;
    forever begin
      @(negedge clk);
      #1;
      if (walk_enable) begin
        wv = walk_vaddr;
        walker_done = 0;
        repeat (drop_delay) @(negedge clk);
        walk_ready = 0;
        for (int k = 0; k < walk_lat; k++) begin
          @(negedge clk);
          flush_w = flush_on_walk && (k == 1);
        end
        flush_w = 0;
        flush_on_walk = 0;
        walk_pte_array = build_line(wv);
        walk_ready = 1;
        walker_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      if (walk_enable) en_cnt++;
      if (hold_pend && !resp_valid) begin
        check({cur, "_hold_paddr"}, resp_paddr, last_pa);
        check({cur, "_hold_fault"}, 64'(resp_fault), 64'(last_f));
        hold_pend = 0;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check({cur, "_spurious_resp"}, 1, 0);
        end else begin
          e = sb.pop_front();
          check({cur, "_paddr"}, resp_paddr, e.pa);
          check({cur, "_fault"}, 64'(resp_fault), 64'(e.f));
          check({cur, "_walk_pulses"}, 64'(en_cnt - e.e0),
                64'(e.walk ? 1 : 0));
          if (e.walk) begin
            check({cur, "_walk_vaddr"}, walk_vaddr, e.va);
            check({cur, "_fill_after_walk"}, 64'(walker_done), 1);
          end else begin
            check({cur, "_hit_latency"}, 64'(cyc - e.c0), 1);
          end
          last_pa = e.pa;
          last_f = e.f;
          hold_pend = 1;
        end
      end
    end
  end

  task automatic do_req(input logic [63:0] va, input bit walk,
                        input bit fl_lookup);
    exp_t e;
    logic [63:0] pte;
    int n;
    @(negedge clk);
    req_valid = 1;
    req_vaddr = va;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      check({cur, "_accept"}, 0, 1);
      req_valid = 0;
      return;
    end
    pte = gen_pte(va, int'(va[14:12]));
    e.va = va;
    e.f = !pte[0];
    e.pa = e.f ? 64'h0 : {8'b0, pte[53:10], va[11:0]};
    e.walk = walk;
    e.c0 = cyc;
    e.e0 = en_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 0;
    if (fl_lookup) begin
      @(negedge clk);
      flush_tb = 1;
      @(negedge clk);
      flush_tb = 0;
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({cur, "_timeout"}, 0, 1);
      sb.delete();
    end
    @(negedge clk);
    #2;
  endtask

  task automatic wait_walker;
    int n;
    n = 0;
    while (!walker_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!walker_done) check("walker_idle_timeout", 0, 1);
  endtask

  initial begin
    logic [63:0] va;
    int n;
    reset = 1;
    flush_tb = 0;
    req_valid = 0;
    req_vaddr = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 0);
    check("rst_resp_valid", 64'(resp_valid), 0);
    check("rst_resp_fault", 64'(resp_fault), 0);
    check("rst_walk_enable", 64'(walk_enable), 0);
    check("rst_resp_paddr", resp_paddr, 0);
    check("rst_walk_vaddr", walk_vaddr, 0);
    @(negedge clk);
    reset = 0;

    cur = "t1";
    do_req(T1, 1, 0);
    check("t1_paddr_const", resp_paddr, 64'h0000_0000_8000_1678);
    check("t1_fault_const", 64'(resp_fault), 0);

    cur = "t2";
    do_req(64'h0000_0040_1234_5ABC, 0, 0);
    check("t2_paddr_const", resp_paddr, 64'h0000_0000_8000_1ABC);

    cur = "t3";
    do_req(64'h0000_0040_1234_0010, 0, 0);
    check("t3_fault_const", 64'(resp_fault), 1);
    check("t3_paddr_const", resp_paddr, 0);

    cur = "t4";
    @(negedge clk);
    flush_tb = 1;
    @(negedge clk);
    flush_tb = 0;
    for (int t = 0; t < 5; t++) begin
      va = (64'(t) << 15) | (64'(t) << 12) | 64'h123;
      do_req(va, 1, 0);
    end
    do_req(64'h123, 1, 0);
    for (int t = 2; t < 5; t++) begin
      va = (64'(t) << 15) | (64'(t + 1) << 12) | 64'h456;
      do_req(va, 0, 0);
    end

    cur = "t5";
    va = 64'h0000_0000_0032_3ABC;
    flush_on_walk = 1;
    do_req(va, 1, 0);
    do_req(va, 1, 0);
    do_req(va, 0, 0);

    cur = "flush_lookup";
    do_req(va, 1, 1);
    do_req(va, 0, 0);

    cur = "flush_idle";
    @(negedge clk);
    flush_tb = 1;
    req_valid = 1;
    req_vaddr = va;
    #1;
    check("flush_idle_ready", 64'(req_ready), 0);
    @(negedge clk);
    flush_tb = 0;
    req_valid = 0;
    do_req(va, 1, 0);

    cur = "t6";
    drop_delay = 3;
    do_req(64'h0000_0012_3456_7000, 1, 0);
    do_req(64'h0000_0012_3456_6FF0, 0, 0);
    drop_delay = 0;

    cur = "t6_reset";
    walk_lat = 8;
    @(negedge clk);
    req_valid = 1;
    req_vaddr = 64'h0000_0000_0777_1000;
    @(posedge clk);
    #1;
    req_valid = 0;
    n = 0;
    while (!walk_enable && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t6_reset_walk_seen", 64'(walk_enable), 1);
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    check("t6_rst_ready_low", 64'(req_ready), 0);
    check("t6_rst_walk_en_low", 64'(walk_enable), 0);
    @(negedge clk);
    reset = 0;
    #1;
    check("t6_post_rst_ready", 64'(req_ready), 1);
    check("t6_post_rst_resp", 64'(resp_valid), 0);
    wait_walker();
    walk_lat = 4;
    cur = "post_reset";
    do_req(T1, 1, 0);
    do_req(64'h0000_0040_1234_5ABC, 0, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
